// File: rtl/cmd_tx_if.sv
// Caller/crc7-facing signal bundle for the SD CMD-line transmitter cmd_tx.
interface cmd_tx_if;
  logic        istart;
  logic [5:0]  iindex;
  logic [31:0] iarg;
  logic        obusy;
  logic        odone;
  logic        ocmd;
  logic        ocmd_oe;
  logic        ocrc_rst;
  logic        ocrc_data;
  logic        ocrc_unload;
  logic        icrc;

  modport master (
    output istart, iindex, iarg, icrc,
    input  obusy, odone, ocmd, ocmd_oe, ocrc_rst, ocrc_data, ocrc_unload
  );

  modport slave (
    input  istart, iindex, iarg, icrc,
    output obusy, odone, ocmd, ocmd_oe, ocrc_rst, ocrc_data, ocrc_unload
  );
endinterface

// File: rtl/cmd_tx.sv
// SD CMD-line transmitter: serialises start/tx/index/arg/CRC7/end MSB-first, driving an external crc7.
// Optional Ncc idle gap after the end bit is enabled by defining CMD_TX_NCC_GAP_EN.
module cmd_tx #(
  parameter int NCC_CYCLES = 8
) (
  input  logic     iclk,
  input  logic     irst_n,
  cmd_tx_if.slave  bus
);

`ifdef CMD_TX_NCC_GAP_EN
  typedef enum logic [2:0] {IDLE, FRAME, CRC, END, GAP} state_e;
  localparam logic [5:0] GAP_LAST = 6'(NCC_CYCLES - 1);
`else
  typedef enum logic [2:0] {IDLE, FRAME, CRC, END} state_e;
`endif

  state_e      state_q, state_d;
  logic [38:0] shreg_q, shreg_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic        cmd_q, cmd_d;
  logic        oe_q, oe_d;
  logic        done_q, done_d;
  logic        crcRst, crcData, crcUnload;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      cmd_q    <= 1'b1;
      oe_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      cmd_q    <= cmd_d;
      oe_q     <= oe_d;
      done_q   <= done_d;
    end
  end

  // bitcnt counts edges since the start bit: 1..39 data, 40..46 CRC, 47 end bit, 48 release.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    cmd_d     = cmd_q;
    oe_d      = oe_q;
    done_d    = 1'b0;
    crcRst    = 1'b0;
    crcData   = 1'b0;
    crcUnload = 1'b0;
    case (state_q)
      IDLE: begin
        crcRst = ~bus.istart;
        if (bus.istart) begin
          shreg_d  = {1'b1, bus.iindex, bus.iarg};
          cmd_d    = 1'b0;
          oe_d     = 1'b1;
          bitcnt_d = 6'd1;
          state_d  = FRAME;
        end
      end
      FRAME: begin
        cmd_d    = shreg_q[38];
        crcData  = shreg_q[38];
        shreg_d  = {shreg_q[37:0], 1'b0};
        bitcnt_d = bitcnt_q + 6'd1;
        if (bitcnt_q == 6'd39) state_d = CRC;
      end
      CRC: begin
        cmd_d     = bus.icrc;
        crcUnload = 1'b1;
        bitcnt_d  = bitcnt_q + 6'd1;
        if (bitcnt_q == 6'd46) state_d = END;
      end
      END: begin
        cmd_d    = 1'b1;
        bitcnt_d = bitcnt_q + 6'd1;
        if (bitcnt_q == 6'd48) begin
          oe_d     = 1'b0;
          bitcnt_d = '0;
`ifdef CMD_TX_NCC_GAP_EN
          state_d  = GAP;
`else
          state_d  = IDLE;
          done_d   = 1'b1;
`endif
        end
      end
`ifdef CMD_TX_NCC_GAP_EN
      GAP: begin
        bitcnt_d = bitcnt_q + 6'd1;
        if (bitcnt_q == GAP_LAST) begin
          bitcnt_d = '0;
          state_d  = IDLE;
          done_d   = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign bus.obusy       = (state_q != IDLE);
  assign bus.odone       = done_q;
  assign bus.ocmd        = cmd_q;
  assign bus.ocmd_oe     = oe_q;
  assign bus.ocrc_rst    = crcRst;
  assign bus.ocrc_data   = crcData;
  assign bus.ocrc_unload = crcUnload;

endmodule
